// File: rtl/iot_monitor_pkg.sv
// Shared constants and helpers for the multi-channel IoT device monitor.
package iot_monitor_pkg;

    localparam int unsigned MODE_WRAP = 0;
    localparam int unsigned MODE_SAT  = 1;

    // Index/extension width that never collapses to zero bits for small counts.
    function automatic int unsigned clog2_min1(input int unsigned n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/iot_chan_counter.sv
// Single-channel up/down device counter with wrap or clamp at the range limits.
module iot_chan_counter
    import iot_monitor_pkg::*;
#(
    parameter int unsigned WIDTH    = 8,
    parameter int unsigned SATURATE = MODE_WRAP
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             change,
    input  logic             on_off,
    output logic [WIDTH-1:0] count,
    output logic             bnd_c
);

    localparam logic [WIDTH-1:0] CNT_MAX = '1;

    logic at_limit;

    // The step in progress would cross the top (up) or bottom (down) of the range.
    assign at_limit = on_off ? (count == CNT_MAX) : (count == '0);
    assign bnd_c    = change & at_limit;

    always_ff @(posedge clk) begin
        if (rst) begin
            count <= '0;
        end else if (change) begin
            if (at_limit && (SATURATE == MODE_SAT)) begin
                count <= count;
            end else if (on_off) begin
                count <= count + WIDTH'(1);
            end else begin
                count <= count - WIDTH'(1);
            end
        end
    end

endmodule

// File: rtl/iot_monitor_multi.sv
// Multi-channel active-device monitor: per-channel counters, registered total,
// hysteresis alarm, sticky boundary flags and a registered host read-back port.
module iot_monitor_multi
    import iot_monitor_pkg::*;
#(
    parameter  int unsigned WIDTH    = 8,
    parameter  int unsigned NCH      = 4,
    parameter  int unsigned SATURATE = MODE_WRAP,
    parameter  int unsigned HI_TH    = 200,
    parameter  int unsigned LO_TH    = 100,
    localparam int unsigned SEL_W    = clog2_min1(NCH),
    localparam int unsigned TOT_W    = WIDTH + clog2_min1(NCH)
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [NCH-1:0]       change,
    input  logic [NCH-1:0]       on_off,
    input  logic                 clr_flags,
    input  logic [SEL_W-1:0]     rd_sel,
    output logic [WIDTH-1:0]     rd_data,
    output logic [NCH*WIDTH-1:0] counters,
    output logic [TOT_W-1:0]     total,
    output logic                 alarm,
    output logic [NCH-1:0]       bnd_flag
);

    localparam int unsigned NSEL = 1 << SEL_W;

    logic [WIDTH-1:0] cnt    [NCH];
    logic [WIDTH-1:0] rd_tbl [NSEL];
    logic [NCH-1:0]   bnd_ev;
    logic [TOT_W-1:0] sum_c;

    for (genvar g = 0; g < NCH; g++) begin : g_chan
        iot_chan_counter #(
            .WIDTH    (WIDTH),
            .SATURATE (SATURATE)
        ) u_chan (
            .clk    (clk),
            .rst    (rst),
            .change (change[g]),
            .on_off (on_off[g]),
            .count  (cnt[g]),
            .bnd_c  (bnd_ev[g])
        );
        assign counters[g*WIDTH +: WIDTH] = cnt[g];
    end

    // Read table padded to the full select range; unused selects read as zero.
    for (genvar g = 0; g < NSEL; g++) begin : g_rd
        if (g < NCH) begin : g_live
            assign rd_tbl[g] = cnt[g];
        end else begin : g_pad
            assign rd_tbl[g] = '0;
        end
    end

    always_comb begin
        sum_c = '0;
        for (int unsigned i = 0; i < NCH; i++) begin
            sum_c = sum_c + TOT_W'(cnt[i]);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            total    <= '0;
            alarm    <= 1'b0;
            bnd_flag <= '0;
            rd_data  <= '0;
        end else begin
            total <= sum_c;
            // Hysteresis band: between the thresholds the alarm keeps its state.
            if (total > TOT_W'(HI_TH)) begin
                alarm <= 1'b1;
            end else if (total < TOT_W'(LO_TH)) begin
                alarm <= 1'b0;
            end
            // A boundary event in the same cycle survives a clear.
            bnd_flag <= (clr_flags ? '0 : bnd_flag) | bnd_ev;
            rd_data  <= rd_tbl[rd_sel];
        end
    end

endmodule

// File: tb/tb_iot_monitor_multi.sv
// Bench for iot_monitor_multi: wrap and saturate instances driven in lockstep,
// checked against an integer-arithmetic reference model plus directed spot values.
module tb_iot_monitor_multi;
    import iot_monitor_pkg::*;

    localparam int NC = 4;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [3:0]  change = '0;
    logic [3:0]  on_off = '0;
    logic        clr_flags = 1'b0;
    logic [1:0]  rd_sel = '0;

    logic [7:0]  rd_data_w, rd_data_s;
    logic [31:0] counters_w, counters_s;
    logic [9:0]  total_w, total_s;
    logic        alarm_w, alarm_s;
    logic [3:0]  bnd_flag_w, bnd_flag_s;

    int n_checks = 0;
    int n_fail   = 0;

    // Reference state, index 0 = wrap instance, 1 = saturate instance.
    int m_cnt  [2][NC];
    int m_tot  [2];
    int m_alm  [2];
    int m_flag [2][NC];
    int m_rd   [2];

    iot_monitor_multi #(.SATURATE(MODE_WRAP)) u_wrap (
        .clk(clk), .rst(rst), .change(change), .on_off(on_off),
        .clr_flags(clr_flags), .rd_sel(rd_sel), .rd_data(rd_data_w),
        .counters(counters_w), .total(total_w), .alarm(alarm_w), .bnd_flag(bnd_flag_w)
    );

    iot_monitor_multi #(.SATURATE(MODE_SAT)) u_sat (
        .clk(clk), .rst(rst), .change(change), .on_off(on_off),
        .clr_flags(clr_flags), .rd_sel(rd_sel), .rd_data(rd_data_s),
        .counters(counters_s), .total(total_s), .alarm(alarm_s), .bnd_flag(bnd_flag_s)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    // Advance the reference by one clock edge using the behavioural rules.
    task automatic model_edge(input bit r, input logic [3:0] ch, input logic [3:0] up,
                              input bit clr, input int sel);
        for (int m = 0; m < 2; m++) begin
            if (r) begin
                for (int i = 0; i < NC; i++) begin
                    m_cnt[m][i]  = 0;
                    m_flag[m][i] = 0;
                end
                m_tot[m] = 0;
                m_alm[m] = 0;
                m_rd[m]  = 0;
            end else begin
                int s = 0;
                for (int i = 0; i < NC; i++) s += m_cnt[m][i];
                if (m_tot[m] > 200) m_alm[m] = 1;
                else if (m_tot[m] < 100) m_alm[m] = 0;
                m_tot[m] = s;
                m_rd[m]  = (sel < NC) ? m_cnt[m][sel] : 0;
                for (int i = 0; i < NC; i++) begin
                    if (clr) m_flag[m][i] = 0;
                    if (ch[i]) begin
                        int nv = m_cnt[m][i] + (up[i] ? 1 : -1);
                        if (nv > 255 || nv < 0) begin
                            m_flag[m][i] = 1;
                            if (m == 1) nv = (nv > 255) ? 255 : 0;
                            else        nv = (nv > 255) ? 0 : 255;
                        end
                        m_cnt[m][i] = nv;
                    end
                end
            end
        end
    endtask

    task automatic compare_all();
        for (int i = 0; i < NC; i++) begin
            check($sformatf("wrap.cnt%0d", i), 32'(counters_w[i*8 +: 8]), 32'(m_cnt[0][i]));
            check($sformatf("sat.cnt%0d", i),  32'(counters_s[i*8 +: 8]), 32'(m_cnt[1][i]));
            check($sformatf("wrap.flag%0d", i), 32'(bnd_flag_w[i]), 32'(m_flag[0][i]));
            check($sformatf("sat.flag%0d", i),  32'(bnd_flag_s[i]), 32'(m_flag[1][i]));
        end
        check("wrap.total", 32'(total_w), 32'(m_tot[0]));
        check("sat.total",  32'(total_s), 32'(m_tot[1]));
        check("wrap.alarm", 32'(alarm_w), 32'(m_alm[0]));
        check("sat.alarm",  32'(alarm_s), 32'(m_alm[1]));
        check("wrap.rd",    32'(rd_data_w), 32'(m_rd[0]));
        check("sat.rd",     32'(rd_data_s), 32'(m_rd[1]));
    endtask

    // Drive one cycle of inputs, clock it, update the model and compare #1 later.
    task automatic cycle(input bit r, input logic [3:0] ch, input logic [3:0] up,
                         input bit clr, input logic [1:0] sel);
        rst       = r;
        change    = ch;
        on_off    = up;
        clr_flags = clr;
        rd_sel    = sel;
        @(posedge clk);
        model_edge(r, ch, up, clr, int'(sel));
        #1;
        compare_all();
    endtask

    task automatic idle(input int n, input logic [1:0] sel);
        for (int k = 0; k < n; k++) cycle(1'b0, 4'b0000, 4'b0000, 1'b0, sel);
    endtask

    initial begin
        cycle(1'b1, 4'b0000, 4'b0000, 1'b0, 2'd0);
        cycle(1'b1, 4'b0000, 4'b0000, 1'b0, 2'd0);

        // Reset overrides a full-width step mid-sequence
        for (int k = 0; k < 5; k++) cycle(1'b0, 4'b0001, 4'b0001, 1'b0, 2'd0);
        check("t1.ch0_loaded", 32'(counters_w[7:0]), 32'd5);
        idle(2, 2'd0);
        cycle(1'b1, 4'b1111, 4'b1111, 1'b0, 2'd0);
        check("t1.counters", counters_w, 32'd0);
        check("t1.total", 32'(total_w), 32'd0);
        check("t1.alarm", 32'(alarm_w), 32'd0);
        check("t1.flags", 32'(bnd_flag_w), 32'd0);
        check("t1.rd", 32'(rd_data_w), 32'd0);

        // Wrap in both directions
        cycle(1'b0, 4'b0010, 4'b0000, 1'b0, 2'd1);
        cycle(1'b0, 4'b0000, 4'b0000, 1'b1, 2'd1);
        cycle(1'b0, 4'b0010, 4'b0010, 1'b0, 2'd1);
        check("t2.ch1_wrap_up", 32'(counters_w[15:8]), 32'd0);
        check("t2.flags_up", 32'(bnd_flag_w), 32'b0010);
        cycle(1'b0, 4'b0100, 4'b0000, 1'b0, 2'd2);
        check("t2.ch2_wrap_dn", 32'(counters_w[23:16]), 32'd255);

        // Saturation at both ends
        cycle(1'b1, 4'b0000, 4'b0000, 1'b0, 2'd0);
        cycle(1'b0, 4'b0001, 4'b0000, 1'b0, 2'd0);
        check("t3.sat_ch0_low", 32'(counters_s[7:0]), 32'd0);
        check("t3.sat_flag_low", 32'(bnd_flag_s), 32'b0001);
        for (int k = 0; k < 256; k++) cycle(1'b0, 4'b0001, 4'b0001, 1'b0, 2'd0);
        check("t3.sat_ch0_high", 32'(counters_s[7:0]), 32'd255);
        check("t3.sat_flag_high", 32'(bnd_flag_s[0]), 32'd1);

        // All channels step together
        cycle(1'b1, 4'b0000, 4'b0000, 1'b0, 2'd0);
        cycle(1'b0, 4'b1111, 4'b1010, 1'b0, 2'd0);
        check("t4.counters", counters_w, {8'd1, 8'd255, 8'd1, 8'd255});
        idle(1, 2'd0);
        check("t4.total", 32'(total_w), 32'd512);

        // Hysteresis: 201 sets, 150 holds, 99 clears
        cycle(1'b1, 4'b0000, 4'b0000, 1'b0, 2'd0);
        for (int k = 0; k < 50; k++) cycle(1'b0, 4'b1111, 4'b1111, 1'b0, 2'd0);
        cycle(1'b0, 4'b0001, 4'b0001, 1'b0, 2'd0);
        idle(1, 2'd0);
        check("t5.total_201", 32'(total_w), 32'd201);
        idle(1, 2'd0);
        check("t5.alarm_set", 32'(alarm_w), 32'd1);
        for (int k = 0; k < 12; k++) cycle(1'b0, 4'b1111, 4'b0000, 1'b0, 2'd0);
        for (int k = 0; k < 3; k++)  cycle(1'b0, 4'b0001, 4'b0000, 1'b0, 2'd0);
        idle(3, 2'd0);
        check("t5.total_150", 32'(total_w), 32'd150);
        check("t5.alarm_hold", 32'(alarm_w), 32'd1);
        for (int k = 0; k < 12; k++) cycle(1'b0, 4'b1111, 4'b0000, 1'b0, 2'd0);
        for (int k = 0; k < 3; k++)  cycle(1'b0, 4'b0001, 4'b0000, 1'b0, 2'd0);
        idle(3, 2'd0);
        check("t5.total_99", 32'(total_w), 32'd99);
        check("t5.alarm_clear", 32'(alarm_w), 32'd0);

        // Clear racing a boundary event, then read the wrapped channel back
        cycle(1'b1, 4'b0000, 4'b0000, 1'b0, 2'd0);
        cycle(1'b0, 4'b0011, 4'b0000, 1'b0, 2'd3);
        check("t6.flags_pre", 32'(bnd_flag_w), 32'b0011);
        cycle(1'b0, 4'b1000, 4'b0000, 1'b1, 2'd3);
        check("t6.flags_race", 32'(bnd_flag_w), 32'b1000);
        idle(1, 2'd3);
        check("t6.rd_ch3", 32'(rd_data_w), 32'd255);

        // Random traffic with occasional clears and resets
        for (int k = 0; k < 3000; k++) begin
            cycle(($urandom_range(0, 199) == 0),
                  4'($urandom_range(0, 15)),
                  4'($urandom_range(0, 15)),
                  ($urandom_range(0, 15) == 0),
                  2'($urandom_range(0, 3)));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
